// File: rtl/cv32e40p_x_if_pkg.sv
// cv32e40p_x_if_pkg
//   Shared types and constants for the X-interface dispatcher.
//   disp_entry_t records, for each in-flight offload, which accelerator
//   channel took it and whether its response must be forwarded to the core.
//   The channel index is sized for the largest supported channel count so
//   the entry type does not depend on a per-instance parameter.
package cv32e40p_x_if_pkg;

  localparam int X_RD_W    = 5;  // destination register index width
  localparam int X_NUM_RS  = 3;  // source operand count
  localparam int X_MAX_ACC = 8;  // largest supported channel count
  localparam int X_SEL_W   = 3;  // $clog2(X_MAX_ACC)

  typedef struct packed {
    logic [X_SEL_W-1:0] sel;  // channel that accepted the instruction
    logic               wb;   // response is forwarded to the core
  } disp_entry_t;

endpackage

// File: rtl/cv32e40p_x_if_order_fifo.sv
// cv32e40p_x_if_order_fifo
//   DEPTH-entry synchronous FIFO holding the issue order of outstanding
//   offloads. The head entry is presented combinationally so the response
//   path can steer ready/valid in the same cycle.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i         write push_data_i (ignored when full)
//   push_data_i    entry to append
//   pop_i          drop the head entry (ignored when empty)
//   head_o         oldest entry (content undefined while empty)
//   full_o/empty_o occupancy flags
//   count_o        number of stored entries
module cv32e40p_x_if_order_fifo
  import cv32e40p_x_if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  disp_entry_t                  push_data_i,
  input  logic                         pop_i,
  output disp_entry_t                  head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  disp_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so plain pointer overflow wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cv32e40p_x_if_dispatcher.sv
// cv32e40p_x_if_dispatcher
//   Routes instructions offloaded by the core over the X interface to one of
//   NUM_ACC accelerator channels. Each instruction is predecoded against the
//   per-channel mask/match tables; the lowest-index match wins. Unmatched
//   instructions are rejected in the same cycle. Accepted offloads are
//   recorded in an order FIFO so responses return to the core strictly in
//   issue order; responses of channels that do not write back are consumed
//   internally.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   x_q_*                  core request: valid/ready, instruction, operands
//   x_k_accept_o/_writeback_o  same-cycle accept decision for the request
//   x_p_*                  in-order response to the core
//   acc_q_*                per-channel request (instr/operands broadcast)
//   acc_p_*                per-channel response
//   outstanding_o          number of in-flight offloads
module cv32e40p_x_if_dispatcher
  import cv32e40p_x_if_pkg::*;
#(
  parameter int          NUM_ACC              = 2,
  parameter int          DEPTH                = 4,
  parameter logic [31:0] ACC_MASK   [NUM_ACC] = '{32'h0000_007F, 32'h0000_007F},
  parameter logic [31:0] ACC_MATCH  [NUM_ACC] = '{32'h0000_0053, 32'h0000_000B},
  parameter logic [2:0]  ACC_RS_REQ [NUM_ACC] = '{3'b011, 3'b111},
  parameter logic        ACC_WB     [NUM_ACC] = '{1'b1, 1'b1}
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  // core request / accept
  input  logic                              x_q_valid_i,
  output logic                              x_q_ready_o,
  input  logic [31:0]                       x_q_instr_data_i,
  input  logic [X_NUM_RS-1:0][31:0]         x_q_rs_i,
  input  logic [X_NUM_RS-1:0]               x_q_rs_valid_i,
  output logic                              x_k_accept_o,
  output logic                              x_k_writeback_o,
  // core response
  output logic                              x_p_valid_o,
  input  logic                              x_p_ready_i,
  output logic [X_RD_W-1:0]                 x_p_rd_o,
  output logic [31:0]                       x_p_data_o,
  output logic                              x_p_error_o,
  // accelerator requests
  output logic [NUM_ACC-1:0]                acc_q_valid_o,
  input  logic [NUM_ACC-1:0]                acc_q_ready_i,
  output logic [31:0]                       acc_q_instr_data_o,
  output logic [X_NUM_RS-1:0][31:0]         acc_q_rs_o,
  // accelerator responses
  input  logic [NUM_ACC-1:0]                acc_p_valid_i,
  output logic [NUM_ACC-1:0]                acc_p_ready_o,
  input  logic [NUM_ACC-1:0][X_RD_W-1:0]    acc_p_rd_i,
  input  logic [NUM_ACC-1:0][31:0]          acc_p_data_i,
  input  logic [NUM_ACC-1:0]                acc_p_error_i,
  output logic [$clog2(DEPTH+1)-1:0]        outstanding_o
);

  // ---------------------------------------------------------------- predecode
  logic [NUM_ACC-1:0]  hit;
  logic [NUM_ACC-1:0]  sel_oh;
  logic [X_SEL_W-1:0]  sel;
  logic [X_NUM_RS-1:0] sel_rs_req;
  logic                sel_wb;
  logic                any_hit;

  for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_hit
    assign hit[gi] = ((x_q_instr_data_i & ACC_MASK[gi]) == ACC_MATCH[gi]);
  end

  // Scan from the top down so the lowest-index hit is the last one written.
  always_comb begin
    sel        = '0;
    sel_oh     = '0;
    sel_rs_req = '0;
    sel_wb     = 1'b0;
    any_hit    = 1'b0;
    for (int i = NUM_ACC - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel        = X_SEL_W'(i);
        sel_oh     = '0;
        sel_oh[i]  = 1'b1;
        sel_rs_req = ACC_RS_REQ[i];
        sel_wb     = ACC_WB[i];
        any_hit    = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- issue
  logic        fifo_full, fifo_empty;
  logic        rs_ok, issue_ok, acc_handshake;
  logic        push, pop;
  disp_entry_t push_entry, head;

  // Operands the selected channel does not need are treated as present.
  assign rs_ok         = &(x_q_rs_valid_i | ~sel_rs_req);
  // Full stalls issue even if the head retires this cycle: no bypass path.
  assign issue_ok      = x_q_valid_i & ~fifo_full & rs_ok;
  assign acc_q_valid_o = sel_oh & {NUM_ACC{issue_ok}};
  assign acc_handshake = |(acc_q_valid_o & acc_q_ready_i);

  // An unmatched instruction is consumed immediately as a reject.
  assign x_q_ready_o     = any_hit ? acc_handshake : 1'b1;
  assign x_k_accept_o    = acc_handshake;
  assign x_k_writeback_o = acc_handshake & sel_wb;

  assign acc_q_instr_data_o = x_q_instr_data_i;
  assign acc_q_rs_o         = x_q_rs_i;

  assign push           = acc_handshake;
  assign push_entry.sel = sel;
  assign push_entry.wb  = sel_wb;

  cv32e40p_x_if_order_fifo #(
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (outstanding_o)
  );

  // ---------------------------------------------------------------- response
  logic [NUM_ACC-1:0] head_oh;
  logic               head_p_valid;
  logic               head_error;
  logic               head_release;

  always_comb begin
    head_oh      = '0;
    head_p_valid = 1'b0;
    head_error   = 1'b0;
    x_p_rd_o     = '0;
    x_p_data_o   = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (head.sel == X_SEL_W'(i)) begin
        head_oh[i]   = 1'b1;
        head_p_valid = acc_p_valid_i[i];
        head_error   = acc_p_error_i[i];
        x_p_rd_o     = acc_p_rd_i[i];
        x_p_data_o   = acc_p_data_i[i];
      end
    end
  end

  // Non-writeback responses are sunk here without waiting for the core.
  assign head_release  = head.wb ? x_p_ready_i : 1'b1;
  // Only the head channel is ever released; others are held, not dropped.
  assign acc_p_ready_o = fifo_empty ? '0 : (head_oh & {NUM_ACC{head_release}});
  assign x_p_valid_o   = ~fifo_empty & head.wb & head_p_valid;
  assign x_p_error_o   = x_p_valid_o & head_error;
  assign pop           = ~fifo_empty & head_p_valid & head_release;

endmodule

// File: tb/tb_cv32e40p_x_if_dispatcher.sv
module tb_cv32e40p_x_if_dispatcher;

  localparam int DEPTH = 4;
  localparam logic [31:0] MASK  [2] = '{32'h0000_007F, 32'h0000_007F};
  localparam logic [31:0] MATCH [2] = '{32'h0000_0053, 32'h0000_000B};
  localparam logic [2:0]  RSREQ [2] = '{3'b011, 3'b111};
  localparam logic        WB    [2] = '{1'b1, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: default configuration
  logic             rst, q_valid, q_ready, k_accept, k_wb;
  logic [31:0]      instr;
  logic [2:0][31:0] rs;
  logic [2:0]       rs_valid;
  logic             p_valid, p_ready, p_error;
  logic [4:0]       p_rd;
  logic [31:0]      p_data;
  logic [1:0]       aq_valid, aq_ready, ap_valid, ap_ready, ap_error;
  logic [31:0]      aq_instr;
  logic [2:0][31:0] aq_rs;
  logic [1:0][4:0]  ap_rd;
  logic [1:0][31:0] ap_data;
  logic [2:0]       outstanding;

  cv32e40p_x_if_dispatcher u_dut (
    .clk_i(clk), .rst_i(rst),
    .x_q_valid_i(q_valid), .x_q_ready_o(q_ready), .x_q_instr_data_i(instr),
    .x_q_rs_i(rs), .x_q_rs_valid_i(rs_valid),
    .x_k_accept_o(k_accept), .x_k_writeback_o(k_wb),
    .x_p_valid_o(p_valid), .x_p_ready_i(p_ready), .x_p_rd_o(p_rd),
    .x_p_data_o(p_data), .x_p_error_o(p_error),
    .acc_q_valid_o(aq_valid), .acc_q_ready_i(aq_ready),
    .acc_q_instr_data_o(aq_instr), .acc_q_rs_o(aq_rs),
    .acc_p_valid_i(ap_valid), .acc_p_ready_o(ap_ready), .acc_p_rd_i(ap_rd),
    .acc_p_data_i(ap_data), .acc_p_error_i(ap_error),
    .outstanding_o(outstanding)
  );

  // ---------------- DUT B: channel 1 does not write back
  logic             b_rst, b_q_valid, b_q_ready, b_k_accept, b_k_wb;
  logic [31:0]      b_instr;
  logic [2:0][31:0] b_rs;
  logic [2:0]       b_rs_valid;
  logic             b_p_valid, b_p_ready, b_p_error;
  logic [4:0]       b_p_rd;
  logic [31:0]      b_p_data;
  logic [1:0]       b_aq_valid, b_aq_ready, b_ap_valid, b_ap_ready, b_ap_error;
  logic [31:0]      b_aq_instr;
  logic [2:0][31:0] b_aq_rs;
  logic [1:0][4:0]  b_ap_rd;
  logic [1:0][31:0] b_ap_data;
  logic [2:0]       b_outstanding;

  cv32e40p_x_if_dispatcher #(.ACC_WB('{1'b1, 1'b0})) u_dut_b (
    .clk_i(clk), .rst_i(b_rst),
    .x_q_valid_i(b_q_valid), .x_q_ready_o(b_q_ready), .x_q_instr_data_i(b_instr),
    .x_q_rs_i(b_rs), .x_q_rs_valid_i(b_rs_valid),
    .x_k_accept_o(b_k_accept), .x_k_writeback_o(b_k_wb),
    .x_p_valid_o(b_p_valid), .x_p_ready_i(b_p_ready), .x_p_rd_o(b_p_rd),
    .x_p_data_o(b_p_data), .x_p_error_o(b_p_error),
    .acc_q_valid_o(b_aq_valid), .acc_q_ready_i(b_aq_ready),
    .acc_q_instr_data_o(b_aq_instr), .acc_q_rs_o(b_aq_rs),
    .acc_p_valid_i(b_ap_valid), .acc_p_ready_o(b_ap_ready), .acc_p_rd_i(b_ap_rd),
    .acc_p_data_i(b_ap_data), .acc_p_error_i(b_ap_error),
    .outstanding_o(b_outstanding)
  );

  // ---------------- checking
  int n_checks = 0;
  int n_pass   = 0;
  bit verbose  = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model: in-flight list in issue order
  typedef struct { int sel; bit wb; } ent_t;
  ent_t mq[$];
  int   pend[2];   // responses each accelerator still owes

  // Called just after a falling edge with inputs applied; checks outputs,
  // then advances the model across the rising edge.
  task automatic step_a();
    int         s;
    bit         full, rs_ok, v, hs, pop;
    logic       e_ready, e_acc, e_wb, e_pv;
    logic [1:0] e_aqv, e_apr;
    ent_t       h, e;
    #1;
    s = -1;
    for (int i = 0; i < 2; i++)
      if (s < 0 && (instr & MASK[i]) == MATCH[i]) s = i;
    full = (mq.size() >= DEPTH);
    e_aqv = 2'b00; hs = 1'b0;
    if (s < 0) begin
      e_ready = 1'b1; e_acc = 1'b0; e_wb = 1'b0;
    end else begin
      rs_ok = ((rs_valid & RSREQ[s]) == RSREQ[s]);
      v     = q_valid && !full && rs_ok;
      if (v) e_aqv[s] = 1'b1;
      hs      = v && aq_ready[s];
      e_ready = hs; e_acc = hs; e_wb = hs && WB[s];
    end
    e_pv = 1'b0; e_apr = 2'b00; pop = 1'b0;
    if (mq.size() > 0) begin
      h = mq[0];
      if (h.wb) begin
        e_pv = ap_valid[h.sel];
        if (p_ready) e_apr[h.sel] = 1'b1;
        pop = e_pv && p_ready;
      end else begin
        e_apr[h.sel] = 1'b1;
        pop = ap_valid[h.sel];
      end
    end
    check("q_ready",     q_ready,     e_ready);
    check("k_accept",    k_accept,    e_acc);
    check("k_writeback", k_wb,        e_wb);
    check("acc_q_valid", aq_valid,    e_aqv);
    check("acc_q_instr", aq_instr,    instr);
    for (int i = 0; i < 3; i++) check("acc_q_rs", aq_rs[i], rs[i]);
    check("p_valid",     p_valid,     e_pv);
    check("acc_p_ready", ap_ready,    e_apr);
    check("outstanding", outstanding, mq.size());
    if (e_pv) begin
      check("p_data",  p_data,  ap_data[h.sel]);
      check("p_rd",    p_rd,    ap_rd[h.sel]);
      check("p_error", p_error, ap_error[h.sel]);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      pend[0] = 0; pend[1] = 0;
    end else begin
      if (pop) begin
        e = mq.pop_front();
        pend[e.sel]--;
        if (verbose) $display("retire ch%0d wb=%0d data=%08h", e.sel, e.wb, ap_data[e.sel]);
      end
      if (hs) begin
        e.sel = s; e.wb = WB[s];
        mq.push_back(e);
        pend[s]++;
        if (verbose) $display("issue  ch%0d instr=%08h", s, instr);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_a();
    q_valid = 1'b0; instr = 32'h0000_0053; rs_valid = 3'b000; aq_ready = 2'b00;
    p_ready = 1'b0; ap_valid = 2'b00; ap_error = 2'b00;
    for (int i = 0; i < 3; i++) rs[i] = 32'h1000 + i;
    ap_rd[0] = 5'd1; ap_rd[1] = 5'd2; ap_data[0] = '0; ap_data[1] = '0;
  endtask

  task automatic idle_b();
    b_q_valid = 1'b0; b_instr = 32'h0000_0053; b_rs_valid = 3'b000; b_aq_ready = 2'b00;
    b_p_ready = 1'b0; b_ap_valid = 2'b00; b_ap_error = 2'b00;
    for (int i = 0; i < 3; i++) b_rs[i] = '0;
    b_ap_rd[0] = 5'd3; b_ap_rd[1] = 5'd4; b_ap_data[0] = 32'h11; b_ap_data[1] = 32'h22;
  endtask

  task automatic randomize_a();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 4)
      0:       instr = {r[31:7], 7'h53};
      1:       instr = {r[31:7], 7'h0B};
      2:       instr = {r[31:7], 7'h33};
      default: instr = r;
    endcase
    q_valid  = ($urandom % 4) != 0;
    rs_valid = ($urandom % 2) ? 3'b111 : 3'($urandom);
    for (int i = 0; i < 3; i++) rs[i] = $urandom;
    p_ready  = ($urandom % 10) < 7;
    for (int i = 0; i < 2; i++) begin
      aq_ready[i] = ($urandom % 10) < 7;
      ap_valid[i] = (pend[i] > 0) && ($urandom % 2 == 0);
      ap_data[i]  = $urandom;
      ap_rd[i]    = 5'($urandom);
      ap_error[i] = ($urandom % 8) == 0;
    end
    // Nothing in flight: stray responses must simply be held off.
    if (mq.size() == 0) ap_valid = 2'($urandom);
    rst = ($urandom % 300) == 0;
    if (rst) begin
      q_valid = 1'b0; ap_valid = 2'b00;
    end
  endtask

  initial begin
    idle_a(); idle_b();
    rst = 1'b1; b_rst = 1'b1;
    pend[0] = 0; pend[1] = 0;
    @(negedge clk);
    step_a(); step_a();
    rst = 1'b0; b_rst = 1'b0;
    check("reset_outstanding", outstanding, 0);
    check("reset_p_valid", p_valid, 0);

    // single FPU-class offload, accepted same cycle
    q_valid = 1'b1; instr = 32'h0000_0053; rs_valid = 3'b011; aq_ready = 2'b01;
    #1;
    check("t1_ready", q_ready, 1); check("t1_accept", k_accept, 1);
    check("t1_wb", k_wb, 1); check("t1_aqv", aq_valid, 2'b01);
    step_a();
    check("t1_outstanding", outstanding, 1);
    q_valid = 1'b0; ap_valid = 2'b01; ap_data[0] = 32'hA0; p_ready = 1'b1;
    #1; check("t1_resp_data", p_data, 32'hA0);
    step_a();
    ap_valid = 2'b00;

    // no match: rejected, nothing queued
    q_valid = 1'b1; instr = 32'h0000_0033;
    #1;
    check("nomatch_ready", q_ready, 1); check("nomatch_accept", k_accept, 0);
    check("nomatch_aqv", aq_valid, 2'b00);
    step_a();
    check("nomatch_outstanding", outstanding, 0);

    // in-order merging: ch1 answers before ch0
    instr = 32'h0000_0053; rs_valid = 3'b011; aq_ready = 2'b01; step_a();
    instr = 32'h0000_000B; rs_valid = 3'b111; aq_ready = 2'b10; step_a();
    q_valid = 1'b0; aq_ready = 2'b00;
    ap_valid = 2'b10; ap_data[1] = 32'hB; p_ready = 1'b1;
    repeat (2) begin
      #1; check("order_hold_ch1", ap_ready[1], 0); check("order_hold_pv", p_valid, 0);
      step_a();
    end
    ap_valid = 2'b11; ap_data[0] = 32'hA;
    #1; check("order_first", p_data, 32'hA); check("order_first_rdy", ap_ready, 2'b01);
    step_a();
    ap_valid = 2'b10;
    #1; check("order_second", p_data, 32'hB); check("order_second_rdy", ap_ready, 2'b10);
    step_a();
    ap_valid = 2'b00;

    // fill to DEPTH, then full stall and no bypass on pop
    p_ready = 1'b0; q_valid = 1'b1; instr = 32'h0000_0053; rs_valid = 3'b111; aq_ready = 2'b01;
    repeat (DEPTH) step_a();
    #1; check("full_stall", q_ready, 0); check("full_count", outstanding, DEPTH);
    step_a();
    ap_valid = 2'b01; ap_data[0] = 32'h5; p_ready = 1'b1;
    #1; check("full_no_bypass", q_ready, 0);
    step_a();
    check("after_pop_count", outstanding, 3);
    #1; check("pushpop_ready", q_ready, 1);
    step_a();
    check("pushpop_count", outstanding, 3);
    q_valid = 1'b0;
    repeat (3) begin ap_valid = {1'b0, pend[0] > 0}; step_a(); end
    ap_valid = 2'b00;
    check("drained", outstanding, 0);

    // operand gating for ch1
    q_valid = 1'b1; instr = 32'h0000_000B; rs_valid = 3'b011; aq_ready = 2'b11;
    #1; check("rs_stall_ready", q_ready, 0); check("rs_stall_aqv", aq_valid, 2'b00);
    step_a();
    rs_valid = 3'b111;
    #1; check("rs_ok_ready", q_ready, 1); check("rs_ok_aqv", aq_valid, 2'b10);
    step_a();
    q_valid = 1'b0; ap_valid = 2'b10; p_ready = 1'b1; step_a();
    ap_valid = 2'b00;

    // randomized traffic
    verbose = 1'b0;
    repeat (3000) begin randomize_a(); step_a(); end
    idle_a(); rst = 1'b1; step_a(); rst = 1'b0; step_a();
    $display("random phase done, %0d checks so far", n_checks);

    // DUT B: non-writeback channel is sunk internally
    b_q_valid = 1'b1; b_instr = 32'h0000_000B; b_rs_valid = 3'b111; b_aq_ready = 2'b10;
    #1;
    check("b_accept", b_k_accept, 1); check("b_wb", b_k_wb, 0); check("b_ready", b_q_ready, 1);
    $display("B issue  ch1 instr=%08h", b_instr);
    @(posedge clk); @(negedge clk);
    b_q_valid = 1'b0;
    check("b_outstanding1", b_outstanding, 1);
    b_ap_valid = 2'b10; b_p_ready = 1'b0;
    #1; check("b_sink_ready", b_ap_ready, 2'b10); check("b_sink_pv", b_p_valid, 0);
    $display("B retire ch1 (sunk)");
    @(posedge clk); @(negedge clk);
    b_ap_valid = 2'b00;
    check("b_outstanding0", b_outstanding, 0);

    // DUT B: reset mid-flight, late response is held off
    b_q_valid = 1'b1; b_instr = 32'h0000_0053; b_rs_valid = 3'b011; b_aq_ready = 2'b01;
    #1; check("b_ch0_wb", b_k_wb, 1);
    $display("B issue  ch0 instr=%08h", b_instr);
    @(posedge clk); @(negedge clk);
    b_q_valid = 1'b0; b_rst = 1'b1;
    check("b_pre_reset_count", b_outstanding, 1);
    @(posedge clk); @(negedge clk);
    b_rst = 1'b0;
    check("b_reset_count", b_outstanding, 0);
    b_ap_valid = 2'b01; b_p_ready = 1'b1;
    #1; check("b_late_ready", b_ap_ready, 2'b00); check("b_late_pv", b_p_valid, 0);
    @(posedge clk); @(negedge clk);
    check("b_late_count", b_outstanding, 0);
    idle_b();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cv32e40p_x_if_dispatcher.md
Name: cv32e40p_x_if_dispatcher

Overview:
Parametrised X-interface dispatcher between the CV32E40P offload port and NUM_ACC independent accelerators (FPU subsystem, future co-processors). It predecodes each offloaded instruction against per-channel mask/match tables and routes it to the lowest-index matching channel. It tracks all outstanding offloads in an order FIFO, so responses return to the core strictly in issue order. It replaces the fixed single-accelerator wrapper and adds multi-channel routing, in-order response merging and internal sinking of non-writeback responses.

Parameters:
NUM_ACC, 2, number of accelerator channels (1..8)
DEPTH, 4, maximum outstanding offloads (power of two, >=2)
ACC_MASK, '{32'h0000_007F,32'h0000_007F}, per-channel instruction bit mask
ACC_MATCH, '{32'h0000_0053,32'h0000_000B}, per-channel match value (instr & mask == match)
ACC_RS_REQ, '{3'b011,3'b111}, per-channel required rs_valid bits
ACC_WB, '{1'b1,1'b1}, per-channel: accepted instructions write rd back to the core

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active high
x_q_valid_i  in  1  core offload request valid
x_q_ready_o  out  1  request consumed (accepted or rejected)
x_q_instr_data_i  in  32  instruction word
x_q_rs_i  in  3x32  source operands
x_q_rs_valid_i  in  3  operand valid flags
x_k_accept_o  out  1  instruction accepted by some channel
x_k_writeback_o  out  1  accepted instruction will write rd
x_p_valid_o  out  1  response valid to core
x_p_ready_i  in  1  core ready for response
x_p_rd_o  out  5  destination register
x_p_data_o  out  32  result
x_p_error_o  out  1  accelerator error
acc_q_valid_o  out  NUM_ACC  per-channel request valid
acc_q_ready_i  in  NUM_ACC  per-channel request ready
acc_q_instr_data_o  out  32  instruction (broadcast)
acc_q_rs_o  out  3x32  operands (broadcast)
acc_p_valid_i  in  NUM_ACC  per-channel response valid
acc_p_ready_o  out  NUM_ACC  per-channel response ready
acc_p_rd_i  in  NUM_ACCx5  per-channel rd
acc_p_data_i  in  NUM_ACCx32  per-channel result
acc_p_error_i  in  NUM_ACC  per-channel error
outstanding_o  out  $clog2(DEPTH+1)  number of in-flight offloads

Behaviour:
- Clock clk_i; reset rst_i synchronous, active high. Reset: FIFO empty, pointers and count 0; all outputs 0 except data/rd/instr/rs, which pass through combinationally.
- Predecode (combinational): hit[i] = (instr & ACC_MASK[i]) == ACC_MATCH[i]; sel = lowest-index hit.
- No hit: x_q_ready_o=1, x_k_accept_o=0, no acc_q_valid asserted. The instruction is rejected in the same cycle and not queued.
- Hit: acc_q_valid_o[sel] = x_q_valid_i & ~full & rs_ok, where rs_ok = &(x_q_rs_valid_i | ~ACC_RS_REQ[sel]). x_q_ready_o = acc_q_valid_o[sel] & acc_q_ready_i[sel]. x_k_accept_o = x_k_writeback_o-qualifier = x_q_ready_o; x_k_writeback_o = x_q_ready_o & ACC_WB[sel].
- Full, or rs_ok=0: request stalls (ready=0); no acc_q_valid. Full blocks issue even when a pop occurs in the same cycle (no bypass).
- On accept handshake: push {sel, ACC_WB[sel]} into the order FIFO. Latency from accept to push visibility is 1 cycle.
- Every accepted instruction yields exactly one accelerator response.
- Response path (combinational from FIFO head h): only acc_p_ready_o[h.sel] may be 1. If h.wb: x_p_valid_o = ~empty & acc_p_valid_i[h.sel], acc_p_ready_o[h.sel] = ~empty & x_p_ready_i. If ~h.wb: x_p_valid_o=0, acc_p_ready_o[h.sel] = ~empty (sunk internally).
- rd/data/error are muxed from h.sel. Pop on acc_p_valid & acc_p_ready of the head channel.
- Responses from non-head channels, or any response while empty: held off (ready=0), never dropped.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH. outstanding_o equals count.
- Reset mid-operation: FIFO is cleared; late accelerator responses after reset see ready=0 until new issues.

Decomposition:
- Add to cv32e40p_x_if_pkg: typedef disp_entry_t {logic [$clog2(NUM_ACC)-1:0] sel; logic wb;}; constant X_RD_W=5.
- Sub-module cv32e40p_x_if_order_fifo: DEPTH-entry sync FIFO with push/pop, full/empty, count, synchronous active-high reset.

Test Plan:
- Instr 32'h0000_0053 with rs_valid=3'b011 and acc_q_ready_i=2'b01 -> same-cycle ready=1, accept=1, writeback=1; acc_q_valid_o=2'b01; outstanding_o becomes 1.
- Instr 32'h0000_0033 (no match) -> ready=1, accept=0, acc_q_valid_o=0, outstanding_o unchanged.
- Issue ch0 then ch1; ch1 responds first (data 0xB) and ch0 2 cycles later (data 0xA) -> core sees 0xA then 0xB; acc_p_ready_o[1] stays 0 until ch0 pops.
- Issue 4 instrs with no responses -> 5th stalls (ready=0) until one response pops; a simultaneous push+pop at count 3 keeps count 3.
- ACC_WB[1]=0: ch1 instr responds -> acc_p_ready_o[1]=1 with x_p_ready_i=0, x_p_valid_o=0; entry pops.
- Ch1 instr 32'h0000_000B with rs_valid=3'b011 (needs 3'b111) -> stall; rs_valid=3'b111 next cycle -> accept.
